// File: rtl/mcac_pkg.sv
// Shared constants, FSM encoding and the 16-bit accumulate helper for the predictor block.
// The helper saturates when PREDICTOR_ACCUM_SAT_EN is defined and wraps otherwise.
package mcac_pkg;

  localparam int NUM_ZEROS = 6;
  localparam int NUM_POLES = 2;
  localparam int PROD_W    = 16;
  localparam int EST_W     = 15;
  localparam int IDX_W     = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // The G.726 bit-exact path wraps; the saturating variant clamps to the 16-bit range.
  function automatic logic [PROD_W-1:0] add16(input logic [PROD_W-1:0] a,
                                              input logic [PROD_W-1:0] b);
    logic [PROD_W-1:0] s;
    s = a + b;
`ifdef PREDICTOR_ACCUM_SAT_EN
    if ((a[PROD_W-1] == b[PROD_W-1]) && (s[PROD_W-1] != a[PROD_W-1])) begin
      s = a[PROD_W-1] ? {1'b1, {(PROD_W-1){1'b0}}} : {1'b0, {(PROD_W-1){1'b1}}};
    end
`endif
    return s;
  endfunction

endpackage

// File: rtl/predictor_accum_if.sv
// Bundle of the predictor start/product request side and its index/result side.
// Handshake: start is sampled only in IDLE; done is a one-cycle strobe marking new sez/se.
interface predictor_accum_if;
  import mcac_pkg::*;

  logic              start;
  logic [PROD_W-1:0] wprod;
  logic [IDX_W-1:0]  idx;
  logic              busy;
  logic              done;
  logic [EST_W-1:0]  sez;
  logic [EST_W-1:0]  se;
  state_e            dbg_state;

  modport master (output start, wprod,
                  input  idx, busy, done, sez, se, dbg_state);
  modport slave  (input  start, wprod,
                  output idx, busy, done, sez, se, dbg_state);
endinterface

// File: rtl/predictor_accum.sv
// Sequential sum of the six zero-section and two pole-section products of the predictor.
// Optional saturating adds selected by PREDICTOR_ACCUM_SAT_EN (default: 16-bit modulo).
module predictor_accum
  import mcac_pkg::*;
(
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_START,
  input  logic [PROD_W-1:0] I16_WPROD,
  output logic [IDX_W-1:0]  O3_IDX,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic [EST_W-1:0]  O15_SEZ,
  output logic [EST_W-1:0]  O15_SE,
  output state_e            O_DBG_STATE
);

  localparam logic [IDX_W-1:0] IDX_SEZ  = IDX_W'(NUM_ZEROS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ZEROS + NUM_POLES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [EST_W-1:0]  sezi_q, sezi_d;
  logic [EST_W-1:0]  sez_q, sez_d;
  logic [EST_W-1:0]  se_q, se_d;
  logic              done_q, done_d;
  logic [PROD_W-1:0] sum;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      sezi_q  <= '0;
      sez_q   <= '0;
      se_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sezi_q  <= sezi_d;
      sez_q   <= sez_d;
      se_q    <= se_d;
      done_q  <= done_d;
    end
  end

  assign sum = add16(acc_q, I16_WPROD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sezi_d  = sezi_q;
    sez_d   = sez_q;
    se_d    = se_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          state_d = ST_ACC;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      ST_ACC: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        // Only bits [15:1] of the snapshot are ever published, so only those are kept.
        if (idx_q == IDX_SEZ) begin
          sezi_d = sum[PROD_W-1:1];
        end
        if (idx_q == IDX_LAST) begin
          sez_d   = sezi_q;
          se_d    = sum[PROD_W-1:1];
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign O3_IDX      = idx_q;
  assign O_BUSY      = (state_q == ST_ACC);
  assign O_DONE      = done_q;
  assign O15_SEZ     = sez_q;
  assign O15_SE      = se_q;
  assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_predictor_accum.sv
// Self-checking bench for predictor_accum: directed table, random runs against an
// integer reference model, and hand-written start/reset corner sequences.
module tb_predictor_accum;
  import mcac_pkg::*;

  logic clk;
  logic rst_n;
  logic [15:0] prod_tab [8];

  predictor_accum_if bus();

  predictor_accum dut (
    .I_CLK       (clk),
    .I_RST_N     (rst_n),
    .I_START     (bus.start),
    .I16_WPROD   (bus.wprod),
    .O3_IDX      (bus.idx),
    .O_BUSY      (bus.busy),
    .O_DONE      (bus.done),
    .O15_SEZ     (bus.sez),
    .O15_SE      (bus.se),
    .O_DBG_STATE (bus.dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External FMULT stand-in: product for whatever index the DUT selects.
  always_comb bus.wprod = prod_tab[bus.idx];

  int n_vec;
  int n_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer sum of the products, wrapped or clamped per add.
  function automatic void model(input logic [15:0] p [8],
                                output logic [14:0] sez, output logic [14:0] se);
    int acc;
    int sezi;
    logic [31:0] t;
    acc  = 0;
    sezi = 0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + int'($signed(p[i]));
`ifdef PREDICTOR_ACCUM_SAT_EN
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
`else
      t   = acc;
      acc = int'($signed(t[15:0]));
`endif
      if (i == 5) sezi = acc;
    end
    t   = sezi;
    sez = t[15:1];
    t   = acc;
    se  = t[15:1];
  endfunction

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 8; i++) prod_tab[i] = v;
  endtask

  // Driver: one start pulse, then wait (bounded) for done and check latency and results.
  task automatic run_one(input string nm, input logic [14:0] esez, input logic [14:0] ese);
    int k;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
    k = 0;
    got = 0;
    while (k < 20 && !got) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.done) got = 1;
    end
    check({nm, "_latency"}, k, 32'd8);
    check({nm, "_sez"}, {17'd0, bus.sez}, {17'd0, esez});
    check({nm, "_se"}, {17'd0, bus.se}, {17'd0, ese});
    @(posedge clk);
    #1;
    check({nm, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({nm, "_hold"}, {2'd0, bus.sez, bus.se}, {2'd0, esez, ese});
  endtask

  typedef struct {
    string       name;
    logic [15:0] prod;
    logic [14:0] exp_sez;
    logic [14:0] exp_se;
  } vec_t;

  vec_t vecs [5];
  logic [14:0] exp_q [$];

  initial begin
    int k;
    int n_done;
    logic [14:0] msez, mse;
    n_vec = 0;
    n_err = 0;
    bus.start = 1'b0;
    set_all(16'h0000);

    vecs[0] = '{"ones",  16'h0001, 15'h0003, 15'h0004};
    vecs[1] = '{"minus1", 16'hFFFF, 15'h7FFD, 15'h7FFC};
`ifdef PREDICTOR_ACCUM_SAT_EN
    vecs[2] = '{"q4000", 16'h4000, 15'h3FFF, 15'h3FFF};
    vecs[3] = '{"q8000", 16'h8000, 15'h4000, 15'h4000};
`else
    vecs[2] = '{"q4000", 16'h4000, 15'h4000, 15'h0000};
    vecs[3] = '{"q8000", 16'h8000, 15'h0000, 15'h0000};
`endif
    vecs[4] = '{"zero",  16'h0000, 15'h0000, 15'h0000};

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idx",   {29'd0, bus.idx}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_sez",   {17'd0, bus.sez}, 32'd0);
    check("rst_se",    {17'd0, bus.se}, 32'd0);
    check("rst_state", {31'd0, bus.dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      set_all(vecs[i].prod);
      run_one(vecs[i].name, vecs[i].exp_sez, vecs[i].exp_se);
      check({vecs[i].name, "_idle_idx"}, {29'd0, bus.idx}, 32'd0);
    end

    // Random products vs. reference model
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 8; i++) begin
        if (r < 8) prod_tab[i] = 16'($urandom_range(0, 65535));
        else prod_tab[i] = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(16'h3000, 16'h7FFF))
                                                       : 16'($urandom_range(16'h8000, 16'hCFFF));
      end
      model(prod_tab, msez, mse);
      run_one($sformatf("rand%0d", r), msez, mse);
    end

    // Start re-pulsed mid-run is ignored: one done only, at the normal latency
    set_all(16'h0001);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    n_done = 0;
    while (k < 25) begin
      if (bus.idx == 3'd3 && bus.busy) bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      k++;
      if (bus.done) begin
        n_done++;
        check("repulse_latency", k, 32'd8);
      end
    end
    check("repulse_done_count", n_done, 32'd1);
    check("repulse_sez", {17'd0, bus.sez}, 32'h3);

    // Back-to-back: start held during the done cycle starts a second run
    exp_q.push_back(15'h7FFD);
    exp_q.push_back(15'h7FFC);
    set_all(16'hFFFF);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    while (k < 20 && !bus.done) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("b2b_first_latency", k, 32'd8);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_restart_busy", {31'd0, bus.busy}, 32'd1);
    set_all(16'h0001);
    k = 1;
    while (k < 20 && !bus.done) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("b2b_second_gap", k, 32'd9);
    check("b2b_second_sez", {17'd0, bus.sez}, 32'h3);
    check("b2b_second_se",  {17'd0, bus.se}, 32'h4);
    // First run's results were the queued values; ensure model agrees with them.
    set_all(16'hFFFF);
    model(prod_tab, msez, mse);
    check("b2b_queue_sez", {17'd0, exp_q.pop_front()}, {17'd0, msez});
    check("b2b_queue_se",  {17'd0, exp_q.pop_front()}, {17'd0, mse});

    // Reset mid-run at index 4
    set_all(16'h1234);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    while (k < 20 && bus.idx != 3'd4) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("midrst_reach_idx4", {29'd0, bus.idx}, 32'd4);
    rst_n = 1'b0;
    #1;
    check("midrst_sez",  {17'd0, bus.sez}, 32'd0);
    check("midrst_se",   {17'd0, bus.se}, 32'd0);
    check("midrst_idx",  {29'd0, bus.idx}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    n_done = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("midrst_no_done", n_done, 32'd0);
    check("midrst_still_idle", {31'd0, bus.busy}, 32'd0);
    set_all(16'h0001);
    run_one("post_rst", 15'h0003, 15'h0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/predictor_accum.md
PREDICTOR_ACCUM -- requirements
Module: predictor_accum

Interface
REQ-001 I_CLK  input  1  single clock; all state updates on rising edge.
REQ-002 I_RST_N  input  1  asynchronous, active-low reset.
REQ-003 I_START  input  1  request one predictor evaluation; single-cycle pulse or level.
REQ-004 I16_WPROD  input  16  two's-complement product from the external FMULT for the currently selected index, valid in the same cycle.
REQ-005 O3_IDX  output  3  selects the operand pair for the external mux and FMULT: 0..5 = B1*DQ1..B6*DQ6, 6..7 = A1*SR1, A2*SR2.
REQ-006 O_BUSY  output  1  high while accumulating.
REQ-007 O_DONE  output  1  one-cycle pulse when the results update.
REQ-008 O15_SEZ  output  15  two's-complement partial (zero-section) signal estimate.
REQ-009 O15_SE  output  15  two's-complement full signal estimate.

Function
REQ-010 FSM states: IDLE and ACC.
REQ-011 IDLE with I_START high at an edge: enter ACC, clear the 16-bit accumulator, set O3_IDX to 0.
REQ-012 ACC, each edge: accumulator += I16_WPROD (16-bit modulo), then O3_IDX increments; eight edges total.
REQ-013 Edge accumulating index 5: snapshot accumulator-plus-product as SEZI.
REQ-014 Edge accumulating index 7:
- O15_SEZ = SEZI[15:1], O15_SE = SEI[15:1], where SEI is the final sum.
- O_DONE high for the following cycle.
- State returns to IDLE.
REQ-015 Latency: I_START sampled at edge N produces O_DONE high in the cycle after edge N+8.
REQ-016 I_START is ignored while in ACC.
REQ-017 I_START high in the O_DONE cycle starts a new run; back-to-back throughput is one result per 9 cycles.
REQ-018 O15_SEZ and O15_SE hold between completions.
REQ-019 O3_IDX is 0 in IDLE.
REQ-020 O_BUSY is high exactly in ACC.

Reset
REQ-021 Reset asserted:
- state to IDLE;
- O3_IDX, accumulator, SEZI, O15_SEZ, O15_SE to 0;
- O_BUSY and O_DONE to 0.
REQ-022 Reset asserted mid-run aborts the run with no O_DONE and no output update.
REQ-023 After reset deasserts, the next start behaves as a fresh run.

Configuration
REQ-024 Macro PREDICTOR_ACCUM_SAT_EN defined: each addition saturates to 0x7FFF / 0x8000 instead of wrapping.
REQ-025 Macro PREDICTOR_ACCUM_SAT_EN undefined: all additions are 16-bit modulo, as required by the G.726 bit-exact path.
REQ-026 Saturation applies identically to the SEZI snapshot and to SEI.

Structure
REQ-027 Shared package mcac_pkg holds:
- NUM_ZEROS = 6, NUM_POLES = 2;
- product width 16, estimate width 15;
- the FSM state encoding.
REQ-028 No sub-module is instantiated; FMULT and the operand mux remain external, driven by O3_IDX.

Verification
REQ-029 All products 0x0001 -> O15_SEZ = 0x0003, O15_SE = 0x0004, O_DONE in cycle N+9.
REQ-030 All products 0xFFFF -> O15_SEZ = 0x7FFD, O15_SE = 0x7FFC.
REQ-031 All products 0x4000, macro undefined -> O15_SEZ = 0x4000, O15_SE = 0x0000.
REQ-032 All products 0x4000, macro defined -> O15_SEZ = 0x3FFF, O15_SE = 0x3FFF.
REQ-033 I_START re-pulsed at index 3 -> ignored, single O_DONE at N+9. I_START in the O_DONE cycle -> second O_DONE 9 cycles later.
REQ-034 I_RST_N low at index 4 -> outputs 0, no O_DONE. Subsequent run with products 0x0001 -> O15_SEZ = 0x0003, O15_SE = 0x0004.
